// File: rtl/slt_arb_pkg.sv
// rtl/slt_arb_pkg.sv - shared types and constants for the two-port slt arbiter
package slt_arb_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/slt.sv
// rtl/slt.sv - 32-bit set-less-than comparator with signed-subtract overflow flag
module slt (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        u,
    output logic [31:0] q,
    output logic        of
);

    logic borrow_in;
    logic diff_msb;
    logic lt;

    // Bit 31 of a-b rebuilt from the borrow out of the low 31 bits.
    assign borrow_in = (a[30:0] < b[30:0]);
    assign diff_msb  = a[31] ^ b[31] ^ borrow_in;
    assign of        = (a[31] != b[31]) && (diff_msb != a[31]);
    assign lt        = u ? (a < b) : ($signed(a) < $signed(b));
    assign q         = {31'b0, lt};

endmodule

// File: rtl/slt_arbiter.sv
// rtl/slt_arbiter.sv - round-robin share of one slt comparator between two requesters
// SLT_ARB_OF_EN adds the registered overflow output rsp_of.
module slt_arbiter
    import slt_arb_pkg::*;
#(
    parameter int DATA_W = slt_arb_pkg::DATA_W,
    parameter bit FAIR   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req0_u,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic              req1_u,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_q,
`ifdef SLT_ARB_OF_EN
    output logic              rsp_of,
`endif
    output logic              busy
);

    state_t            state;
    logic              last_grant;
    logic              grant_id;
    logic              winner;
    logic              any_req;
    logic              rsp_done;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic              u_r;
    logic [DATA_W-1:0] q_r;
    logic [31:0]       slt_q;
`ifdef SLT_ARB_OF_EN
    logic              slt_of;
    logic              of_r;
`endif

    assign any_req = req0_valid | req1_valid;

    always_comb begin
        winner = REQ1;
        if (FAIR && req0_valid && req1_valid)
            winner = ~last_grant;
        else if (req0_valid)
            winner = REQ0;
    end

    // Ready is gated by reset so a held request is never seen as accepted.
    assign req0_ready = !reset && (state == IDLE) && req0_valid && (winner == REQ0);
    assign req1_ready = !reset && (state == IDLE) && req1_valid && (winner == REQ1);
    assign rsp0_valid = (state == RESP) && (grant_id == REQ0);
    assign rsp1_valid = (state == RESP) && (grant_id == REQ1);
    assign rsp_done   = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
    assign rsp_q      = q_r;
    assign busy       = (state != IDLE);
`ifdef SLT_ARB_OF_EN
    assign rsp_of     = of_r;
`endif

    slt u_slt (
        .a  (a_r),
        .b  (b_r),
        .u  (u_r),
        .q  (slt_q),
`ifdef SLT_ARB_OF_EN
        .of (slt_of)
`else
        .of ()
`endif
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= REQ1;
            grant_id   <= REQ0;
            a_r        <= '0;
            b_r        <= '0;
            u_r        <= 1'b0;
            q_r        <= '0;
`ifdef SLT_ARB_OF_EN
            of_r       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        a_r      <= winner ? req1_a : req0_a;
                        b_r      <= winner ? req1_b : req0_b;
                        u_r      <= winner ? req1_u : req0_u;
                        grant_id <= winner;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    q_r   <= slt_q;
`ifdef SLT_ARB_OF_EN
                    of_r  <= slt_of;
`endif
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_done) begin
                        last_grant <= grant_id;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_slt_arbiter.sv
// tb/tb_slt_arbiter.sv - scoreboard bench for slt_arbiter with random and directed traffic
`timescale 1ns/1ps
module tb_slt_arbiter;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        u;
    } op_t;

    typedef struct {
        logic        id;
        logic [31:0] q;
        logic        of;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rv [2];
    logic [31:0] ra [2];
    logic [31:0] rb [2];
    logic        ru [2];
    logic        req_rdy [2];
    logic        rsp_vld [2];
    logic        rsp_rdy [2];
    logic [31:0] rsp_q;
    logic        busy;
    logic        rsp_of;

    logic        f_rv0 = 1'b0, f_rv1 = 1'b0, f_sr = 1'b0;
    logic [31:0] f_a = 32'h5, f_b = 32'h9;
    logic        f_rr0, f_rr1, f_sv0, f_sv1, f_busy, f_of;
    logic [31:0] f_q;
    int          f_g1 = 0, f_n0 = 0;

    int   total = 0, bad = 0, cyc = 0;
    int   rdy_mode = 1, load_pct = 100;
    op_t  q0 [$];
    op_t  q1 [$];
    exp_t sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    slt_arbiter #(.DATA_W(32), .FAIR(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(rv[0]), .req0_ready(req_rdy[0]), .req0_a(ra[0]), .req0_b(rb[0]), .req0_u(ru[0]),
        .req1_valid(rv[1]), .req1_ready(req_rdy[1]), .req1_a(ra[1]), .req1_b(rb[1]), .req1_u(ru[1]),
        .rsp0_valid(rsp_vld[0]), .rsp0_ready(rsp_rdy[0]),
        .rsp1_valid(rsp_vld[1]), .rsp1_ready(rsp_rdy[1]),
        .rsp_q(rsp_q),
`ifdef SLT_ARB_OF_EN
        .rsp_of(rsp_of),
`endif
        .busy(busy)
    );

    slt_arbiter #(.DATA_W(32), .FAIR(1'b0)) dut_fixed (
        .clk(clk), .reset(reset),
        .req0_valid(f_rv0), .req0_ready(f_rr0), .req0_a(f_a), .req0_b(f_b), .req0_u(1'b0),
        .req1_valid(f_rv1), .req1_ready(f_rr1), .req1_a(f_b), .req1_b(f_a), .req1_u(1'b0),
        .rsp0_valid(f_sv0), .rsp0_ready(f_sr),
        .rsp1_valid(f_sv1), .rsp1_ready(f_sr),
        .rsp_q(f_q),
`ifdef SLT_ARB_OF_EN
        .rsp_of(f_of),
`endif
        .busy(f_busy)
    );

`ifndef SLT_ARB_OF_EN
    assign rsp_of = 1'b0;
    assign f_of   = 1'b0;
`endif

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic on 64-bit integers.
    function automatic exp_t model(input logic id, input logic [31:0] a, input logic [31:0] b,
                                   input logic u, input int c);
        exp_t   e;
        longint sa, sbv, d;
        sa  = $signed(a);
        sbv = $signed(b);
        d   = sa - sbv;
        e.id  = id;
        e.cyc = c;
        e.q   = (u ? (a < b) : (sa < sbv)) ? 32'd1 : 32'd0;
        e.of  = (d > 64'sd2147483647) || (d < -64'sd2147483648);
        return e;
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic add_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic u);
        op_t o;
        o.a = a; o.b = b; o.u = u;
        if (i == 0) q0.push_back(o); else q1.push_back(o);
    endtask

    task automatic step();
        bit  acc [2];
        op_t o;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            acc[i] = rv[i] && req_rdy[i];
            if (acc[i]) sb.push_back(model(i == 1, ra[i], rb[i], ru[i], cyc));
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (acc[i]) rv[i] = 1'b0;
            if (!rv[i] && ((i == 0) ? q0.size() : q1.size()) > 0 && $urandom_range(0, 99) < load_pct) begin
                o = (i == 0) ? q0.pop_front() : q1.pop_front();
                ra[i] = o.a; rb[i] = o.b; ru[i] = o.u; rv[i] = 1'b1;
            end
        end
        case (rdy_mode)
            0: begin rsp_rdy[0] = ($urandom_range(0, 3) != 0); rsp_rdy[1] = ($urandom_range(0, 3) != 0); end
            2: begin rsp_rdy[0] = 1'b1; rsp_rdy[1] = 1'b0; end
            3: begin rsp_rdy[0] = 1'b0; rsp_rdy[1] = 1'b0; end
            default: begin rsp_rdy[0] = 1'b1; rsp_rdy[1] = 1'b1; end
        endcase
    endtask

    task automatic run_until_idle(input int bound);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || rv[0] || rv[1] || sb.size() > 0) && n < bound) begin
            step();
            n++;
        end
        check("drain_pending", 64'(q0.size() + q1.size() + sb.size()) | {62'b0, rv[1], rv[0]}, 0);
    endtask

    // Monitor: invariants, arbitration reference and scoreboard pops.
    initial begin : monitor
        logic last_served = 1'b1;
        bit   seen_valid  = 1'b0;
        exp_t e;
        logic [1:0] want;
        forever begin
            @(negedge clk);
            if (reset) begin
                last_served = 1'b1;
                seen_valid  = 1'b0;
                continue;
            end
            check("rsp_valid_excl", rsp_vld[0] & rsp_vld[1], 0);
            if (busy) begin
                check("no_accept_busy", {req_rdy[1], req_rdy[0]}, 0);
            end else begin
                want = 2'b00;
                if (rv[0] && rv[1]) want = last_served ? 2'b01 : 2'b10;
                else if (rv[0])     want = 2'b01;
                else if (rv[1])     want = 2'b10;
                check("grant", {req_rdy[1], req_rdy[0]}, want);
            end
            for (int i = 0; i < 2; i++) begin
                if (rsp_vld[i]) begin
                    if (sb.size() == 0) begin
                        check("rsp_unexpected", 1, 0);
                    end else begin
                        e = sb[0];
                        check("rsp_id", i, e.id);
                        check("rsp_q", rsp_q, e.q);
`ifdef SLT_ARB_OF_EN
                        check("rsp_of", rsp_of, e.of);
`endif
                        if (!seen_valid) check("latency", cyc, e.cyc + 2);
                        seen_valid = 1'b1;
                        if (rsp_rdy[i]) begin
                            void'(sb.pop_front());
                            last_served = (i == 1);
                            seen_valid  = 1'b0;
                        end
                    end
                end
            end
        end
    end

    initial begin : fixed_counter
        forever begin
            @(negedge clk);
            if (f_rr1) f_g1++;
            if (f_sv0 && f_sr) f_n0++;
        end
    end

    initial begin : driver
        int n;
        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b0; ra[i] = '0; rb[i] = '0; ru[i] = 1'b0; rsp_rdy[i] = 1'b1;
        end
        #1;
        check("reset_rdy", {req_rdy[1], req_rdy[0]}, 0);
        check("reset_vld", {rsp_vld[1], rsp_vld[0]}, 0);
        check("reset_q", rsp_q, 0);
        check("reset_busy", busy, 0);
        check("reset_of", rsp_of, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        add_op(0, 32'hFFFF_FFFF, 32'h1, 1'b0);
        add_op(0, 32'hFFFF_FFFF, 32'h1, 1'b1);
        add_op(0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        add_op(0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
        add_op(1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
        add_op(1, 32'h5, 32'h5, 1'b0);
        run_until_idle(100);

        for (int k = 0; k < 4; k++) begin
            add_op(0, rnd_val(), rnd_val(), 1'(k));
            add_op(1, rnd_val(), rnd_val(), 1'(k >> 1));
        end
        run_until_idle(100);

        rdy_mode = 2;
        add_op(1, 32'h3, 32'h8000_0000, 1'b0);
        n = 0;
        while (!rsp_vld[1] && n < 20) begin step(); n++; end
        check("stall_reached", rsp_vld[1], 1);
        add_op(0, 32'h1, 32'h2, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step();
            check("stall_hold_vld", rsp_vld[1], 1);
            check("stall_no_req0", req_rdy[0], 0);
        end
        rdy_mode = 1;
        run_until_idle(50);

        rdy_mode = 3;
        add_op(0, 32'h2, 32'h1, 1'b0);
        n = 0;
        while (!rsp_vld[0] && n < 20) begin step(); n++; end
        check("reset_resp_reached", rsp_vld[0], 1);
        reset = 1'b1;
        sb.delete();
        for (int i = 0; i < 2; i++) begin
            ra[i] = 32'h10 + i; rb[i] = 32'h20; ru[i] = 1'b0; rv[i] = 1'b1;
        end
        #1;
        check("mid_reset_rdy", {req_rdy[1], req_rdy[0]}, 0);
        check("mid_reset_vld", {rsp_vld[1], rsp_vld[0]}, 0);
        check("mid_reset_q", rsp_q, 0);
        check("mid_reset_busy", busy, 0);
        check("mid_reset_of", rsp_of, 0);
        step();
        step();
        reset = 1'b0;
        rdy_mode = 1;
        step();
        check("post_reset_req0_first", {rv[1], rv[0]}, 2'b10);
        run_until_idle(50);

        @(posedge clk);
        #1 f_sr = 1'b1; f_rv0 = 1'b1; f_rv1 = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        check("fixed_req1_blocked", f_g1, 0);
        check("fixed_req0_served", f_n0 > 10, 1);
        f_rv0 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("fixed_req1_after", f_g1 > 0, 1);
        f_rv1 = 1'b0;

        rdy_mode = 0;
        load_pct = 50;
        for (int k = 0; k < 250; k++) begin
            add_op(0, rnd_val(), rnd_val(), 1'($urandom_range(0, 1)));
            add_op(1, rnd_val(), rnd_val(), 1'($urandom_range(0, 1)));
        end
        run_until_idle(20000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
